// File: rtl/mem_wb_pipe_if.sv
// MEM->WB pipeline bus: instruction fields in, last-stage fields and forwarding out.
interface mem_wb_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned CNT_W  = 16
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [ADDR_W-1:0] addr_i;
  logic [CTRL_W-1:0] memtoreg_i;
  logic              regwrite_i;
  logic [ADDR_W-1:0] rs_addr_i;
  logic [DATA_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] addr_o;
  logic [CTRL_W-1:0] memtoreg_o;
  logic              regwrite_o;
  logic              valid_o;
  logic              fwd_hit_o;
  logic [DATA_W-1:0] fwd_data_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, mem_data_i, addr_i, memtoreg_i, regwrite_i, rs_addr_i,
    input  mem_data_o, addr_o, memtoreg_o, regwrite_o, valid_o, fwd_hit_o, fwd_data_o,
           stall_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, mem_data_i, addr_i, memtoreg_i, regwrite_i, rs_addr_i,
    output mem_data_o, addr_o, memtoreg_o, regwrite_o, valid_o, fwd_hit_o, fwd_data_o,
           stall_cnt_o
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB register chain, STAGES deep, with stall/flush, forwarding lookup and a
// saturating stall counter. Stage 0 is youngest; the last stage drives the outputs.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_wb_pipe_if.slave  bus
);

  localparam int NStg = int'(STAGES);
  localparam int Last = NStg - 1;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("mem_wb_pipe: STAGES must be in 1..4");
  end

  logic [DATA_W-1:0] r_data     [NStg];
  logic [ADDR_W-1:0] r_addr     [NStg];
  logic [CTRL_W-1:0] r_memtoreg [NStg];
  logic [NStg-1:0]   r_regwrite;
  logic [NStg-1:0]   r_valid;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_load0;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  // Stage 0 is written on a flush (bubble) even while the older stages hold.
  assign w_load0 = bus.flush_i | ~bus.stall_i;

  // Stage registers: bubble/load into stage 0, shift the rest unless stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NStg; k++) begin
        r_data[k]     <= '0;
        r_addr[k]     <= '0;
        r_memtoreg[k] <= '0;
        r_regwrite[k] <= 1'b0;
        r_valid[k]    <= 1'b0;
      end
    end else begin
      if (w_load0) begin
        if (bus.flush_i) begin
          r_data[0]     <= '0;
          r_addr[0]     <= '0;
          r_memtoreg[0] <= '0;
          r_regwrite[0] <= 1'b0;
          r_valid[0]    <= 1'b0;
        end else begin
          r_data[0]     <= bus.mem_data_i;
          r_addr[0]     <= bus.addr_i;
          r_memtoreg[0] <= bus.memtoreg_i;
          r_regwrite[0] <= bus.regwrite_i & bus.valid_i;
          r_valid[0]    <= bus.valid_i;
        end
      end
      if (!bus.stall_i) begin
        for (int k = 1; k < NStg; k++) begin
          r_data[k]     <= r_data[k-1];
          r_addr[k]     <= r_addr[k-1];
          r_memtoreg[k] <= r_memtoreg[k-1];
          r_regwrite[k] <= r_regwrite[k-1];
          r_valid[k]    <= r_valid[k-1];
        end
      end
    end
  end

  // Stall counter: counts every stalled edge (flush included) and sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (bus.stall_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Forwarding lookup: walk oldest to youngest so the youngest match wins; r0 never matches.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = Last; k >= 0; k--) begin
      if (r_valid[k] && r_regwrite[k] && (r_addr[k] == bus.rs_addr_i) && (r_addr[k] != '0)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[k];
      end
    end
  end

  assign bus.mem_data_o  = r_data[Last];
  assign bus.addr_o      = r_addr[Last];
  assign bus.memtoreg_o  = r_memtoreg[Last];
  assign bus.regwrite_o  = r_regwrite[Last] & r_valid[Last];
  assign bus.valid_o     = r_valid[Last];
  assign bus.fwd_hit_o   = w_fwd_hit;
  assign bus.fwd_data_o  = w_fwd_data;
  assign bus.stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench: DUT A (STAGES=2, CNT_W=16) and DUT B (STAGES=3, CNT_W=4) share stimulus.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall, flush, valid, regwrite;
  logic [31:0] data;
  logic [4:0]  addr, rs_addr;
  logic [1:0]  memtoreg;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5), .CTRL_W(2), .CNT_W(16)) if_a ();
  mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5), .CTRL_W(2), .CNT_W(4))  if_b ();

  assign if_a.stall_i = stall;    assign if_b.stall_i = stall;
  assign if_a.flush_i = flush;    assign if_b.flush_i = flush;
  assign if_a.valid_i = valid;    assign if_b.valid_i = valid;
  assign if_a.mem_data_i = data;  assign if_b.mem_data_i = data;
  assign if_a.addr_i = addr;      assign if_b.addr_i = addr;
  assign if_a.memtoreg_i = memtoreg; assign if_b.memtoreg_i = memtoreg;
  assign if_a.regwrite_i = regwrite; assign if_b.regwrite_i = regwrite;
  assign if_a.rs_addr_i = rs_addr;   assign if_b.rs_addr_i = rs_addr;

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CTRL_W(2), .STAGES(2), .CNT_W(16)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CTRL_W(2), .STAGES(3), .CNT_W(4)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic [4:0] a,
                        input logic [1:0] m, input logic rw);
    valid = v; data = d; addr = a; memtoreg = m; regwrite = rw;
  endtask

  task automatic do_reset();
    stall = 1'b0; flush = 1'b0; rs_addr = '0;
    set_in(1'b0, '0, '0, '0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stall = 1'b0; flush = 1'b0; rs_addr = '0;
    set_in(1'b0, '0, '0, '0, 1'b0);
    #1;
    n_vec++; if (if_a.valid_o !== 1'b0 || if_a.mem_data_o !== 32'h0 || if_a.regwrite_o !== 1'b0)
      begin n_bad++; $display("FAIL reset_a: valid=%0d data=%h rw=%0d want 0", if_a.valid_o,
                              if_a.mem_data_o, if_a.regwrite_o); end
    n_vec++; if (if_b.valid_o !== 1'b0 || if_b.addr_o !== 5'd0 || if_b.stall_cnt_o !== 4'd0)
      begin n_bad++; $display("FAIL reset_b: valid=%0d addr=%0d cnt=%0d want 0", if_b.valid_o,
                              if_b.addr_o, if_b.stall_cnt_o); end
    do_reset();
  endtask

  // Latency: captured at edge 0, visible after edge STAGES-1.
  task automatic test_latency();
    do_reset();
    set_in(1'b1, 32'hDEADBEEF, 5'd5, 2'd2, 1'b1);
    step();
    set_in(1'b0, '0, '0, '0, 1'b0);
    n_vec++; if (if_a.valid_o !== 1'b0)
      begin n_bad++; $display("FAIL lat_a_early: valid=%0d want 0", if_a.valid_o); end
    step();
    n_vec++; if (if_a.valid_o !== 1'b1 || if_a.mem_data_o !== 32'hDEADBEEF || if_a.addr_o !== 5'd5
                 || if_a.memtoreg_o !== 2'd2 || if_a.regwrite_o !== 1'b1)
      begin n_bad++; $display("FAIL lat_a_out: v=%0d d=%h a=%0d m=%0d rw=%0d want 1 deadbeef 5 2 1",
                              if_a.valid_o, if_a.mem_data_o, if_a.addr_o, if_a.memtoreg_o,
                              if_a.regwrite_o); end
    n_vec++; if (if_b.valid_o !== 1'b0)
      begin n_bad++; $display("FAIL lat_b_early: valid=%0d want 0", if_b.valid_o); end
    step();
    n_vec++; if (if_b.valid_o !== 1'b1 || if_b.mem_data_o !== 32'hDEADBEEF)
      begin n_bad++; $display("FAIL lat_b_out: v=%0d d=%h want 1 deadbeef", if_b.valid_o,
                              if_b.mem_data_o); end
    n_vec++; if (if_a.valid_o !== 1'b0 || if_a.regwrite_o !== 1'b0)
      begin n_bad++; $display("FAIL lat_a_bubble: v=%0d rw=%0d want 0 0", if_a.valid_o,
                              if_a.regwrite_o); end
  endtask

  // Fill B, stall three edges, then drain: no loss, no duplication.
  task automatic test_stall();
    logic [31:0] exp_seq [4];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h100 + i, 5'(i + 1), 2'd1, 1'b1);
      step();
    end
    n_vec++; if (if_b.mem_data_o !== 32'h100)
      begin n_bad++; $display("FAIL stall_fill: d=%h want 100", if_b.mem_data_o); end
    set_in(1'b1, 32'h103, 5'd4, 2'd1, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (if_b.mem_data_o !== 32'h100 || if_b.addr_o !== 5'd1 || if_b.valid_o !== 1'b1)
        begin n_bad++; $display("FAIL stall_hold%0d: d=%h a=%0d v=%0d want 100 1 1", i,
                                if_b.mem_data_o, if_b.addr_o, if_b.valid_o); end
    end
    n_vec++; if (if_b.stall_cnt_o !== 4'd3 || if_a.stall_cnt_o !== 16'd3)
      begin n_bad++; $display("FAIL stall_cnt: b=%0d a=%0d want 3 3", if_b.stall_cnt_o,
                              if_a.stall_cnt_o); end
    stall = 1'b0;
    exp_seq[0] = 32'h101; exp_seq[1] = 32'h102; exp_seq[2] = 32'h103; exp_seq[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      set_in(1'b0, '0, '0, '0, 1'b0);
      n_vec++; if (if_b.mem_data_o !== exp_seq[i] || if_b.valid_o !== (i < 3))
        begin n_bad++; $display("FAIL stall_drain%0d: d=%h v=%0d want %h %0d", i,
                                if_b.mem_data_o, if_b.valid_o, exp_seq[i], (i < 3)); end
    end
  endtask

  // Flush and stall together: stage 0 becomes a bubble, older stages hold.
  task automatic test_flush_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h200 + i, 5'(i + 10), 2'd0, 1'b1);
      step();
    end
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    set_in(1'b0, '0, '0, '0, 1'b0);
    n_vec++; if (if_b.mem_data_o !== 32'h200 || if_b.valid_o !== 1'b1 || if_b.stall_cnt_o !== 4'd1)
      begin n_bad++; $display("FAIL fs_hold: d=%h v=%0d cnt=%0d want 200 1 1", if_b.mem_data_o,
                              if_b.valid_o, if_b.stall_cnt_o); end
    rs_addr = 5'd12; #1;
    n_vec++; if (if_b.fwd_hit_o !== 1'b0)
      begin n_bad++; $display("FAIL fs_bubble_fwd: hit=%0d want 0", if_b.fwd_hit_o); end
    rs_addr = 5'd11; #1;
    n_vec++; if (if_b.fwd_hit_o !== 1'b1 || if_b.fwd_data_o !== 32'h201)
      begin n_bad++; $display("FAIL fs_stage1_fwd: hit=%0d d=%h want 1 201", if_b.fwd_hit_o,
                              if_b.fwd_data_o); end
    step();
    n_vec++; if (if_b.mem_data_o !== 32'h201 || if_b.valid_o !== 1'b1)
      begin n_bad++; $display("FAIL fs_next: d=%h v=%0d want 201 1", if_b.mem_data_o,
                              if_b.valid_o); end
    step();
    n_vec++; if (if_b.valid_o !== 1'b0 || if_b.regwrite_o !== 1'b0 || if_b.mem_data_o !== 32'h0)
      begin n_bad++; $display("FAIL fs_bubble_out: v=%0d rw=%0d d=%h want 0 0 0", if_b.valid_o,
                              if_b.regwrite_o, if_b.mem_data_o); end
  endtask

  // Forwarding: youngest match wins, misses give 0, r0 never forwards.
  task automatic test_forward();
    do_reset();
    set_in(1'b1, 32'h33, 5'd7, 2'd0, 1'b1); step();
    set_in(1'b1, 32'h22, 5'd3, 2'd0, 1'b1); step();
    set_in(1'b1, 32'h11, 5'd7, 2'd0, 1'b1); step();
    stall = 1'b1;
    rs_addr = 5'd7; #1;
    n_vec++; if (if_b.fwd_hit_o !== 1'b1 || if_b.fwd_data_o !== 32'h11)
      begin n_bad++; $display("FAIL fwd_young: hit=%0d d=%h want 1 11", if_b.fwd_hit_o,
                              if_b.fwd_data_o); end
    rs_addr = 5'd3; #1;
    n_vec++; if (if_b.fwd_hit_o !== 1'b1 || if_b.fwd_data_o !== 32'h22)
      begin n_bad++; $display("FAIL fwd_mid: hit=%0d d=%h want 1 22", if_b.fwd_hit_o,
                              if_b.fwd_data_o); end
    rs_addr = 5'd9; #1;
    n_vec++; if (if_b.fwd_hit_o !== 1'b0 || if_b.fwd_data_o !== 32'h0)
      begin n_bad++; $display("FAIL fwd_miss: hit=%0d d=%h want 0 0", if_b.fwd_hit_o,
                              if_b.fwd_data_o); end
    stall = 1'b0;
    set_in(1'b1, 32'h44, 5'd7, 2'd0, 1'b0); step();
    rs_addr = 5'd7; #1;
    n_vec++; if (if_b.fwd_hit_o !== 1'b1 || if_b.fwd_data_o !== 32'h11)
      begin n_bad++; $display("FAIL fwd_norw: hit=%0d d=%h want 1 11", if_b.fwd_hit_o,
                              if_b.fwd_data_o); end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h55, 5'd0, 2'd0, 1'b1); step();
    end
    rs_addr = 5'd0; #1;
    n_vec++; if (if_b.fwd_hit_o !== 1'b0 || if_b.fwd_data_o !== 32'h0)
      begin n_bad++; $display("FAIL fwd_r0: hit=%0d d=%h want 0 0", if_b.fwd_hit_o,
                              if_b.fwd_data_o); end
  endtask

  // Asynchronous reset mid-stream, then post-reset latency.
  task automatic test_reset_mid();
    set_in(1'b1, 32'h66, 5'd6, 2'd3, 1'b1);
    stall = 1'b1; step(); stall = 1'b0;
    step(); step(); step();
    rs_addr = 5'd6;
    #3 reset = 1'b1;
    #1;
    n_vec++; if (if_b.valid_o !== 1'b0 || if_b.mem_data_o !== 32'h0 || if_b.regwrite_o !== 1'b0
                 || if_b.memtoreg_o !== 2'd0 || if_b.fwd_hit_o !== 1'b0 || if_b.stall_cnt_o !== 4'd0)
      begin n_bad++; $display("FAIL rmid_b: v=%0d d=%h rw=%0d m=%0d hit=%0d cnt=%0d want all 0",
                              if_b.valid_o, if_b.mem_data_o, if_b.regwrite_o, if_b.memtoreg_o,
                              if_b.fwd_hit_o, if_b.stall_cnt_o); end
    n_vec++; if (if_a.valid_o !== 1'b0 || if_a.addr_o !== 5'd0 || if_a.stall_cnt_o !== 16'd0)
      begin n_bad++; $display("FAIL rmid_a: v=%0d a=%0d cnt=%0d want 0 0 0", if_a.valid_o,
                              if_a.addr_o, if_a.stall_cnt_o); end
    #2 reset = 1'b0;
    set_in(1'b1, 32'hABC, 5'd4, 2'd1, 1'b1);
    step();
    set_in(1'b0, '0, '0, '0, 1'b0);
    step();
    n_vec++; if (if_a.valid_o !== 1'b1 || if_a.mem_data_o !== 32'hABC || if_b.valid_o !== 1'b0)
      begin n_bad++; $display("FAIL rpost_2: a_v=%0d a_d=%h b_v=%0d want 1 abc 0", if_a.valid_o,
                              if_a.mem_data_o, if_b.valid_o); end
    step();
    n_vec++; if (if_b.valid_o !== 1'b1 || if_b.mem_data_o !== 32'hABC || if_b.addr_o !== 5'd4)
      begin n_bad++; $display("FAIL rpost_3: v=%0d d=%h a=%0d want 1 abc 4", if_b.valid_o,
                              if_b.mem_data_o, if_b.addr_o); end
  endtask

  // Counter saturation on the 4-bit instance; the 16-bit one keeps counting.
  task automatic test_saturate();
    do_reset();
    stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14 || i == 15 || i == 20) begin
        n_vec++; if (if_b.stall_cnt_o !== ((i > 15) ? 4'hF : 4'(i)))
          begin n_bad++; $display("FAIL sat_b_%0d: cnt=%0d want %0d", i, if_b.stall_cnt_o,
                                  (i > 15) ? 15 : i); end
      end
    end
    n_vec++; if (if_a.stall_cnt_o !== 16'd20)
      begin n_bad++; $display("FAIL sat_a: cnt=%0d want 20", if_a.stall_cnt_o); end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush_stall();
    test_forward();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
